// File: rtl/panel_pkg.sv
// Shared definitions for the front-panel cursor controller.
//   - PS/2 scancode constants for the keys the panel reacts to
//   - switch action encoding driven onto cursor_action
//   - auto-repeat FSM state type
//   - packed view of the 11-bit ps2_key word
package panel_pkg;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_HOME  = 8'h6C;
  localparam logic [7:0] SC_0     = 8'h45;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;

  typedef enum logic [1:0] {
    ACT_OFF  = 2'd0,
    ACT_UP   = 2'd1,
    ACT_DOWN = 2'd2,
    ACT_SEL  = 2'd3
  } action_e;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  // Bit layout of ps2_key: [10] toggle, [9] make, [8] extended, [7:0] code.
  typedef struct packed {
    logic       toggle;
    logic       make;
    logic       ext;
    logic [7:0] code;
  } ps2_key_t;

  // The four arrow keys repeat; Home moves but never repeats.
  function automatic logic is_arrow(input logic [7:0] code);
    return (code == SC_UP) || (code == SC_DOWN) ||
           (code == SC_LEFT) || (code == SC_RIGHT);
  endfunction

endpackage

// File: rtl/panel_cursor_if.sv
// Key-event in / cursor-out bundle of the panel cursor controller.
//   ps2_key        : 11-bit PS/2 event word from the keyboard decoder
//   cursor_index   : row*COLS + col of the cursor
//   cursor_action  : switch action (off/up/down/select)
//   action_strobe  : one-cycle pulse on every cursor/action write
// master = keyboard side (drives ps2_key), slave = panel_cursor.
interface panel_cursor_if #(
  parameter int IDX_W = 5
);
  logic [10:0]      ps2_key;
  logic [IDX_W-1:0] cursor_index;
  logic [1:0]       cursor_action;
  logic             action_strobe;

  modport master (
    output ps2_key,
    input  cursor_index,
    input  cursor_action,
    input  action_strobe
  );

  modport slave (
    input  ps2_key,
    output cursor_index,
    output cursor_action,
    output action_strobe
  );
endinterface

// File: rtl/key_repeat.sv
// Typematic auto-repeat for held arrow keys.
//   clk, reset : system clock, asynchronous active-low reset
//   arm        : arrow make seen; store key and (re)start the initial delay
//   key        : scancode stored on arm
//   cancel     : break of the stored key; stop repeating
//   tick       : one-cycle request to apply one repeat move of stored_key
//   stored_key : scancode currently being repeated
// Tick rises on the cycle the counter has run down to zero in DELAY or
// REPEAT, so the first repeat lands REPEAT_DELAY+1 cycles after the arm
// and the following ones every REPEAT_RATE+1 cycles.
module key_repeat
  import panel_pkg::*;
#(
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 2_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       arm,
  input  logic [7:0] key,
  input  logic       cancel,
  output logic       tick,
  output logic [7:0] stored_key
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  rpt_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       key_q;

  // Decode of registered state only, so tick is glitch-free.
  assign tick       = (state_q != RPT_IDLE) && (cnt_q == '0);
  assign stored_key = key_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RPT_IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
    end else if (arm) begin
      // A new arrow make always restarts the initial delay, from any state.
      state_q <= RPT_DELAY;
      cnt_q   <= CNT_W'(REPEAT_DELAY);
      key_q   <= key;
    end else if (cancel) begin
      state_q <= RPT_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        RPT_DELAY: begin
          if (cnt_q == '0) begin
            state_q <= RPT_REPEAT;
            cnt_q   <= CNT_W'(REPEAT_RATE);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RPT_REPEAT: begin
          if (cnt_q == '0) begin
            cnt_q <= CNT_W'(REPEAT_RATE);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= RPT_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/panel_cursor.sv
// Keyboard cursor controller for the front-panel switch grid.
//   clk, reset : system clock, asynchronous active-low reset
//   bus        : panel_cursor_if slave
//                ps2_key in; cursor_index, cursor_action, action_strobe out
// ps2_key is registered once; a change of its toggle bit against the
// previous registered value is one event. Arrow/Home makes (extended)
// move the cursor and select; digit makes (non-extended) set the action;
// breaks of 1/2 on a momentary index release the switch. Held arrows
// repeat through key_repeat; a key event on the same cycle as a repeat
// tick wins and the tick is dropped.
module panel_cursor
  import panel_pkg::*;
#(
  parameter int          ROWS           = 2,
  parameter int          COLS           = 16,
  parameter int          LAST_COLS      = 9,
  parameter int          IDX_W          = 5,
  parameter logic [31:0] MOMENTARY_MASK = 32'h007C_0000,
  parameter bit          WRAP           = 1'b1,
  parameter int          REPEAT_DELAY   = 25_000_000,
  parameter int          REPEAT_RATE    = 2_500_000
) (
  input  logic           clk,
  input  logic           reset,
  panel_cursor_if.slave  bus
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  ps2_key_t         key_q;
  logic             toggle_prev_q;
  logic [ROW_W-1:0] row_q, row_n;
  logic [COL_W-1:0] col_q, col_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  action_e          act_q, act_n;
  logic             strobe_q, write_n;

  logic             key_event;
  logic             do_move;
  logic [7:0]       move_key;
  logic             momentary;
  logic [31:0]      mask_shift;
  logic             rpt_arm, rpt_cancel, rpt_tick;
  logic [7:0]       rpt_key;

  // Highest column index of a given row; the last row may be shorter.
  function automatic logic [COL_W-1:0] max_col(input logic [ROW_W-1:0] r);
    return (r == ROW_W'(ROWS - 1)) ? COL_W'(LAST_COLS - 1) : COL_W'(COLS - 1);
  endfunction

  assign key_event = key_q.toggle ^ toggle_prev_q;

  // Indices beyond the 32-bit mask shift to zero and count as latching.
  assign mask_shift = MOMENTARY_MASK >> idx_q;
  assign momentary  = mask_shift[0];

  assign rpt_arm    = key_event && key_q.make && key_q.ext && is_arrow(key_q.code);
  assign rpt_cancel = key_event && !key_q.make && key_q.ext && (key_q.code == rpt_key);

  key_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_key_repeat (
    .clk        (clk),
    .reset      (reset),
    .arm        (rpt_arm),
    .key        (key_q.code),
    .cancel     (rpt_cancel),
    .tick       (rpt_tick),
    .stored_key (rpt_key)
  );

  // NOTE: every variable assigned here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    row_n    = row_q;
    col_n    = col_q;
    act_n    = act_q;
    write_n  = 1'b0;
    do_move  = 1'b0;
    move_key = 8'h00;

    if (key_event) begin
      if (key_q.make) begin
        if (key_q.ext) begin
          if (is_arrow(key_q.code) || (key_q.code == SC_HOME)) begin
            do_move  = 1'b1;
            move_key = key_q.code;
          end
        end else begin
          case (key_q.code)
            SC_0: begin act_n = ACT_OFF;  write_n = 1'b1; end
            SC_1: begin act_n = ACT_UP;   write_n = 1'b1; end
            SC_2: begin act_n = ACT_DOWN; write_n = 1'b1; end
            default: ;
          endcase
        end
      end else if (!key_q.ext && momentary &&
                   ((key_q.code == SC_1) || (key_q.code == SC_2))) begin
        act_n   = ACT_OFF;
        write_n = 1'b1;
      end
    end else if (rpt_tick) begin
      do_move  = 1'b1;
      move_key = rpt_key;
    end

    if (do_move) begin
      act_n   = ACT_SEL;
      write_n = 1'b1;
      case (move_key)
        SC_UP: begin
          if (row_q != '0) row_n = row_q - ROW_W'(1);
          if (col_q > max_col(row_n)) col_n = max_col(row_n);
        end
        SC_DOWN: begin
          if (row_q != ROW_W'(ROWS - 1)) row_n = row_q + ROW_W'(1);
          if (col_q > max_col(row_n)) col_n = max_col(row_n);
        end
        SC_LEFT: begin
          if (col_q == '0) col_n = WRAP ? max_col(row_q) : '0;
          else             col_n = col_q - COL_W'(1);
        end
        SC_RIGHT: begin
          if (col_q >= max_col(row_q)) col_n = WRAP ? '0 : max_col(row_q);
          else                         col_n = col_q + COL_W'(1);
        end
        SC_HOME: begin
          row_n = '0;
          col_n = '0;
        end
        default: ;
      endcase
    end

    idx_n = IDX_W'(int'(row_n) * COLS + int'(col_n));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q         <= '0;
      toggle_prev_q <= 1'b0;
      row_q         <= '0;
      col_q         <= '0;
      idx_q         <= '0;
      act_q         <= ACT_OFF;
      strobe_q      <= 1'b0;
    end else begin
      key_q         <= ps2_key_t'(bus.ps2_key);
      toggle_prev_q <= key_q.toggle;
      strobe_q      <= write_n;
      if (write_n) begin
        row_q <= row_n;
        col_q <= col_n;
        idx_q <= idx_n;
        act_q <= act_n;
      end
    end
  end

  assign bus.cursor_index  = idx_q;
  assign bus.cursor_action = act_q;
  assign bus.action_strobe = strobe_q;

endmodule

// File: tb/tb_panel_cursor.sv
// Directed bench for panel_cursor: two instances (WRAP=1 as dut_a,
// WRAP=0 as dut_b) with short repeat timing. Each driven event that should
// produce a strobe pushes its expected index/action/cycle to a per-DUT
// queue; every observed strobe pops and compares.
module tb_panel_cursor;
  import panel_pkg::*;

  typedef struct {
    int idx;
    int act;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  panel_cursor_if #(.IDX_W(5)) bus_a ();
  panel_cursor_if #(.IDX_W(5)) bus_b ();

  panel_cursor #(
    .ROWS(2), .COLS(16), .LAST_COLS(9), .IDX_W(5),
    .MOMENTARY_MASK(32'h007C_0000), .WRAP(1'b1),
    .REPEAT_DELAY(20), .REPEAT_RATE(5)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  panel_cursor #(
    .ROWS(2), .COLS(16), .LAST_COLS(9), .IDX_W(5),
    .MOMENTARY_MASK(32'h007C_0000), .WRAP(1'b0),
    .REPEAT_DELAY(20), .REPEAT_RATE(5)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  exp_t exp_a[$];
  exp_t exp_b[$];
  int   cyc;
  int   n_checks;
  int   n_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic expect_strobe(input bit which, input int idx, input int act, input int at);
    exp_t e;
    e.idx = idx;
    e.act = act;
    e.cyc = at;
    if (which) exp_b.push_back(e);
    else       exp_a.push_back(e);
  endtask

  task automatic observe(input bit which);
    logic       s;
    logic [4:0] idx;
    logic [1:0] act;
    int         pending;
    exp_t       e;
    string      nm;
    nm      = which ? "b" : "a";
    s       = which ? bus_b.action_strobe : bus_a.action_strobe;
    idx     = which ? bus_b.cursor_index  : bus_a.cursor_index;
    act     = which ? bus_b.cursor_action : bus_a.cursor_action;
    pending = which ? exp_b.size() : exp_a.size();
    if (s === 1'b1) begin
      check($sformatf("%s strobe_expected@%0d", nm, cyc), 32'(pending != 0), 32'd1);
      if (pending != 0) begin
        e = which ? exp_b.pop_front() : exp_a.pop_front();
        check($sformatf("%s index@%0d", nm, cyc),  32'(idx), 32'(e.idx));
        check($sformatf("%s action@%0d", nm, cyc), 32'(act), 32'(e.act));
        check($sformatf("%s strobe_cycle", nm),    32'(cyc), 32'(e.cyc));
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      observe(1'b0);
      observe(1'b1);
    end
  endtask

  task automatic send(input bit which, input bit make, input bit ext, input logic [7:0] sc);
    if (which) bus_b.ps2_key = {~bus_b.ps2_key[10], make, ext, sc};
    else       bus_a.ps2_key = {~bus_a.ps2_key[10], make, ext, sc};
  endtask

  // Arrow/Home make (one strobe two edges later) followed by its break.
  task automatic press(input bit which, input logic [7:0] sc, input int idx);
    send(which, 1'b1, 1'b1, sc);
    expect_strobe(which, idx, ACT_SEL, cyc + 2);
    run(3);
    send(which, 1'b0, 1'b1, sc);
    run(3);
  endtask

  task automatic check_drained(input string tag);
    check({tag, " a_missing"}, 32'(exp_a.size()), 32'd0);
    check({tag, " b_missing"}, 32'(exp_b.size()), 32'd0);
    exp_a.delete();
    exp_b.delete();
  endtask

  initial begin
    int c;
    int c2;
    n_checks      = 0;
    n_pass        = 0;
    cyc           = 0;
    reset         = 1'b0;
    bus_a.ps2_key = '0;
    bus_b.ps2_key = '0;
    run(3);
    check("a reset index",  32'(bus_a.cursor_index),  32'd0);
    check("a reset action", 32'(bus_a.cursor_action), 32'd0);
    check("a reset strobe", 32'(bus_a.action_strobe), 32'd0);
    check("b reset index",  32'(bus_b.cursor_index),  32'd0);
    check("b reset action", 32'(bus_b.cursor_action), 32'd0);
    check("b reset strobe", 32'(bus_b.action_strobe), 32'd0);
    reset = 1'b1;
    run(2);

    // Async reset mid-sequence while a strobe is high at index 5.
    for (int i = 1; i <= 4; i++) press(1'b0, SC_RIGHT, i);
    send(1'b0, 1'b1, 1'b1, SC_RIGHT);
    expect_strobe(1'b0, 5, ACT_SEL, cyc + 2);
    run(2);
    reset = 1'b0;
    #1;
    check("async reset index",  32'(bus_a.cursor_index),  32'd0);
    check("async reset action", 32'(bus_a.cursor_action), 32'd0);
    check("async reset strobe", 32'(bus_a.action_strobe), 32'd0);
    bus_a.ps2_key = '0;
    run(3);
    reset = 1'b1;
    run(40);  // repeat FSM must be idle: no strobes expected
    check_drained("t1");

    // Row moves, saturation, wrap and column clamp.
    press(1'b0, SC_DOWN, 16);
    press(1'b0, SC_RIGHT, 17);
    press(1'b0, SC_RIGHT, 18);
    press(1'b0, SC_RIGHT, 19);
    press(1'b0, SC_DOWN, 19);
    press(1'b0, SC_HOME, 0);
    press(1'b0, SC_LEFT, 15);
    press(1'b0, SC_UP, 15);
    press(1'b0, SC_DOWN, 24);
    check_drained("t2");

    // Momentary release at index 19, latching at index 23.
    press(1'b0, SC_HOME, 0);
    press(1'b0, SC_DOWN, 16);
    for (int i = 17; i <= 19; i++) press(1'b0, SC_RIGHT, i);
    send(1'b0, 1'b1, 1'b0, SC_1);
    expect_strobe(1'b0, 19, ACT_UP, cyc + 2);
    run(3);
    send(1'b0, 1'b0, 1'b0, SC_1);
    expect_strobe(1'b0, 19, ACT_OFF, cyc + 2);
    run(3);
    for (int i = 20; i <= 23; i++) press(1'b0, SC_RIGHT, i);
    send(1'b0, 1'b1, 1'b0, SC_2);
    expect_strobe(1'b0, 23, ACT_DOWN, cyc + 2);
    run(3);
    send(1'b0, 1'b0, 1'b0, SC_2);
    run(4);
    check("latched action", 32'(bus_a.cursor_action), 32'(ACT_DOWN));

    // Arrow code without extended, digit code with extended: ignored.
    send(1'b0, 1'b1, 1'b0, SC_RIGHT);
    run(4);
    send(1'b0, 1'b1, 1'b1, SC_1);
    run(4);
    check("ignored index",  32'(bus_a.cursor_index),  32'd23);
    check("ignored action", 32'(bus_a.cursor_action), 32'(ACT_DOWN));
    check_drained("t4_t6");

    // Held Right: make, then repeats at +21, +27, +33, +39 strobe cycles.
    c = cyc;
    send(1'b0, 1'b1, 1'b1, SC_RIGHT);
    expect_strobe(1'b0, 24, ACT_SEL, c + 2);
    expect_strobe(1'b0, 16, ACT_SEL, c + 23);
    expect_strobe(1'b0, 17, ACT_SEL, c + 29);
    expect_strobe(1'b0, 18, ACT_SEL, c + 35);
    expect_strobe(1'b0, 19, ACT_SEL, c + 41);
    run(42);
    send(1'b0, 1'b0, 1'b1, SC_RIGHT);
    run(25);
    check_drained("t5 hold");

    // Left make during Right repeat restarts the delay with Left.
    c = cyc;
    send(1'b0, 1'b1, 1'b1, SC_RIGHT);
    expect_strobe(1'b0, 20, ACT_SEL, c + 2);
    expect_strobe(1'b0, 21, ACT_SEL, c + 23);
    run(23);
    c2 = cyc;
    send(1'b0, 1'b1, 1'b1, SC_LEFT);
    expect_strobe(1'b0, 20, ACT_SEL, c2 + 2);
    expect_strobe(1'b0, 19, ACT_SEL, c2 + 23);
    run(4);
    send(1'b0, 1'b0, 1'b1, SC_RIGHT);  // break of a non-stored key
    run(19);
    send(1'b0, 1'b0, 1'b1, SC_LEFT);
    run(25);
    check_drained("t5 rearm");

    // Saturating instance.
    press(1'b1, SC_LEFT, 0);
    for (int i = 1; i <= 20; i++) press(1'b1, SC_RIGHT, (i > 15) ? 15 : i);
    check_drained("t3");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
